tmip_action_sched: RTL and testbench

Action scheduler for the template-matching / image-processing (TMIP) engine. It captures the image size and the 2-bit action list delivered on `in_valid_2`, then issues one datapath command at a time over a valid/ready handshake. It waits for each pass's completion pulse and finishes every pattern with a cross-correlation command. It sits between the input port logic and the image-SRAM datapath and owns the running image size and orientation state.

---
 rtl/tmip_action_sched.sv | 187 ++++++++++++++++++
 tb/tb_tmip_action_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmip_action_sched.sv
// Captures image size and action list, then issues one datapath pass at a time; optional flip folding via TMIP_FLIP_FOLD_EN.
// Latency: first cmd_valid two cycles after in_valid_2 falls; each later command at least one cycle after dp_done.
// Backpressure: command fields held stable until cmd_valid && cmd_ready; only one command outstanding.
module tmip_action_sched #(
    parameter int QUEUE_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [4:0] img_size,
    input  logic       in_valid_2,
    input  logic [1:0] action,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_op,
    output logic [4:0] cmd_size,
    output logic [2:0] cmd_orient,
    input  logic       dp_done,
    output logic       busy
);

    localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int PW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PW-1:0] Q_FULL  = PW'(QUEUE_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    localparam logic [2:0] OP_POOL = 3'd0;
    localparam logic [2:0] OP_CORR = 3'd5;
    localparam logic [1:0] ACT_POOL = 2'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_ACT,
        S_COLLECT,
        S_ISSUE,
        S_CMD,
        S_WAIT_DONE
    } state_t;

    state_t        state_q;
    logic [4:0]    size_q;
    logic [2:0]    orient_q;
    logic [1:0]    queue_q [QUEUE_DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic          cmd_valid_q;
    logic [2:0]    cmd_op_q;
    logic [4:0]    cmd_size_q;
    logic [2:0]    cmd_orient_q;
    logic          busy_q;

    logic          push_d;
    logic          q_empty_d;
    logic [1:0]    head_d;

    // The queue only fills during one collect phase and drains once, so it never wraps.
    assign push_d    = in_valid_2 && ((state_q == S_WAIT_ACT) || (state_q == S_COLLECT))
                       && (wr_q != Q_FULL);
    assign q_empty_d = (rd_q == wr_q);
    assign head_d    = queue_q[rd_q[AW-1:0]];

`ifdef TMIP_FLIP_FOLD_EN
    logic [2:0] orient_d;

    // orient is {transpose, mirror_x, mirror_y}; a transpose swaps the two mirrors.
    always_comb begin
        orient_d = orient_q;
        case (head_d)
            2'd1:    orient_d = orient_q ^ 3'b010;
            2'd2:    orient_d = orient_q ^ 3'b001;
            2'd3:    orient_d = {~orient_q[2], orient_q[0], orient_q[1]};
            default: orient_d = orient_q;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (push_d) begin
            queue_q[wr_q[AW-1:0]] <= action;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            size_q       <= '0;
            orient_q     <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_op_q     <= '0;
            cmd_size_q   <= '0;
            cmd_orient_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            if (push_d) begin
                wr_q <= wr_q + PTR_ONE;
            end
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        size_q   <= img_size;
                        orient_q <= '0;
                        wr_q     <= '0;
                        rd_q     <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!in_valid) begin
                        state_q <= S_WAIT_ACT;
                    end
                end
                S_WAIT_ACT: begin
                    if (in_valid_2) begin
                        state_q <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (!in_valid_2) begin
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (q_empty_d) begin
                        cmd_valid_q  <= 1'b1;
                        cmd_op_q     <= OP_CORR;
                        cmd_size_q   <= size_q;
                        cmd_orient_q <= orient_q;
                        state_q      <= S_CMD;
                    end else begin
                        rd_q <= rd_q + PTR_ONE;
                        if (head_d == ACT_POOL) begin
                            // Pooling a 4x4 image is a no-op: pop and stay here.
                            if (size_q > 5'd4) begin
                                cmd_valid_q  <= 1'b1;
                                cmd_op_q     <= OP_POOL;
                                cmd_size_q   <= size_q;
                                cmd_orient_q <= '0;
                                state_q      <= S_CMD;
                            end
                        end else begin
`ifdef TMIP_FLIP_FOLD_EN
                            orient_q <= orient_d;
`else
                            cmd_valid_q  <= 1'b1;
                            cmd_op_q     <= {1'b0, head_d};
                            cmd_size_q   <= size_q;
                            cmd_orient_q <= '0;
                            state_q      <= S_CMD;
`endif
                        end
                    end
                end
                S_CMD: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (dp_done) begin
                        if (cmd_op_q == OP_CORR) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            if (cmd_op_q == OP_POOL) begin
                                size_q <= size_q >> 1;
                            end
                            state_q <= S_ISSUE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_op     = cmd_op_q;
    assign cmd_size   = cmd_size_q;
    assign cmd_orient = cmd_orient_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_tmip_action_sched.sv
// Randomized bench for tmip_action_sched against a command-list reference model.
// Works for both the folded and unfolded flip builds.
module tb_tmip_action_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] img_size;
    logic       in_valid_2;
    logic [1:0] action;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [4:0] cmd_size;
    logic [2:0] cmd_orient;
    logic       dp_done;
    logic       busy;

`ifdef TMIP_FLIP_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] sz;
        logic [2:0] ori;
    } cmd_t;

    cmd_t       exp_q[$];
    logic [1:0] act_arr [16];
    int         n_act;
    int         pat_size;
    int         n_checks = 0;
    int         n_pass   = 0;

    tmip_action_sched #(.QUEUE_DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .img_size   (img_size),
        .in_valid_2 (in_valid_2),
        .action     (action),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_size   (cmd_size),
        .cmd_orient (cmd_orient),
        .dp_done    (dp_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected command list from the action semantics; only the first 8 actions count.
    function automatic void build_expected();
        int s;
        int n;
        bit t, mx, my, tmp;
        s = pat_size; t = 0; mx = 0; my = 0;
        n = (n_act > 8) ? 8 : n_act;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            case (act_arr[i])
                2'd0: if (s > 4) begin
                    exp_q.push_back('{op: 3'd0, sz: 5'(s), ori: 3'd0});
                    s = s / 2;
                end
                2'd1: if (FOLD) mx = !mx; else exp_q.push_back('{op: 3'd1, sz: 5'(s), ori: 3'd0});
                2'd2: if (FOLD) my = !my; else exp_q.push_back('{op: 3'd2, sz: 5'(s), ori: 3'd0});
                default: if (FOLD) begin
                    tmp = mx; mx = my; my = tmp; t = !t;
                end else exp_q.push_back('{op: 3'd3, sz: 5'(s), ori: 3'd0});
            endcase
        end
        exp_q.push_back('{op: 3'd5, sz: 5'(s), ori: FOLD ? {t, mx, my} : 3'd0});
    endfunction

    task automatic load_pattern();
        bit imm;
        @(negedge clk);
        in_valid = 1'b1;
        img_size = 5'(pat_size);
        @(negedge clk);
        check_eq("busy_rise", 32'(busy), 32'(1));
        img_size = 5'(pat_size) ^ 5'b10101;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        for (int i = 0; i < n_act; i++) begin
            in_valid_2 = 1'b1;
            action     = act_arr[i];
            @(negedge clk);
        end
        in_valid_2 = 1'b0;
        action     = 2'($urandom);
        imm = (act_arr[0] == 2'd0) ? (pat_size > 4) : !FOLD;
        @(negedge clk);
        check_eq("lat_issue", 32'(cmd_valid), 32'(0));
        @(negedge clk);
        if (imm) check_eq("lat_cmd", 32'(cmd_valid), 32'(1));
    endtask

    task automatic serve_cmds(input int first_stall);
        int   idx;
        int   stall;
        bit   fin;
        cmd_t c;
        cmd_t cur;
        idx = 0; fin = 0;
        while (!fin && idx <= exp_q.size()) begin
            for (int w = 0; w < 60 && !cmd_valid; w++) @(negedge clk);
            check_eq("cmd_wait", 32'(cmd_valid), 32'(1));
            if (!cmd_valid) break;
            c = '{op: cmd_op, sz: cmd_size, ori: cmd_orient};
            stall = (idx == 0 && first_stall > 0) ? first_stall : int'($urandom_range(0, 3));
            for (int k = 0; k < stall; k++) begin
                cmd_ready = 1'b0;
                dp_done   = (k == 1);
                @(negedge clk);
                dp_done = 1'b0;
                cur = '{op: cmd_op, sz: cmd_size, ori: cmd_orient};
                check_eq("hold", 32'({cmd_valid, cur}), 32'({1'b1, c}));
            end
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
            check_eq("accept_drop", 32'(cmd_valid), 32'(0));
            if (idx < exp_q.size()) check_eq($sformatf("cmd%0d", idx), 32'(c), 32'(exp_q[idx]));
            else check_eq("extra_cmd", 32'(idx), 32'(exp_q.size()));
            idx++;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            dp_done = 1'b1;
            @(negedge clk);
            dp_done = 1'b0;
            check_eq("post_done_gap", 32'(cmd_valid), 32'(0));
            if (c.op == 3'd5) begin
                fin = 1;
                check_eq("busy_fall", 32'(busy), 32'(0));
            end
        end
        check_eq("n_cmds", 32'(idx), 32'(exp_q.size()));
    endtask

    task automatic run_pattern(input int stall);
        build_expected();
        load_pattern();
        serve_cmds(stall);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; img_size = '0; in_valid_2 = 1'b0;
        action = '0; cmd_ready = 1'b0; dp_done = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(cmd_valid), 32'(0));
        check_eq("rst_op", 32'(cmd_op), 32'(0));
        check_eq("rst_size", 32'(cmd_size), 32'(0));
        check_eq("rst_orient", 32'(cmd_orient), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        rst_n = 1'b1;

        pat_size = 16; n_act = 3;
        act_arr[0] = 2'd0; act_arr[1] = 2'd0; act_arr[2] = 2'd0;
        run_pattern(0);

        pat_size = 8; n_act = 3;
        act_arr[0] = 2'd1; act_arr[1] = 2'd3; act_arr[2] = 2'd2;
        run_pattern(0);

        pat_size = 16; n_act = 10;
        act_arr[0] = 2'd1; act_arr[1] = 2'd1; act_arr[2] = 2'd2; act_arr[3] = 2'd2;
        act_arr[4] = 2'd3; act_arr[5] = 2'd3; act_arr[6] = 2'd1; act_arr[7] = 2'd1;
        act_arr[8] = 2'd0; act_arr[9] = 2'd0;
        run_pattern(0);

        pat_size = 8; n_act = 2;
        act_arr[0] = 2'd0; act_arr[1] = 2'd1;
        run_pattern(5);

        // Abort in WAIT_DONE, then a clean size-4 pattern.
        pat_size = 16; n_act = 1; act_arr[0] = 2'd1;
        build_expected();
        load_pattern();
        for (int w = 0; w < 60 && !cmd_valid; w++) @(negedge clk);
        check_eq("rst_test_cmd", 32'(cmd_valid), 32'(1));
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_valid", 32'(cmd_valid), 32'(0));
        check_eq("abort_op", 32'(cmd_op), 32'(0));
        check_eq("abort_size", 32'(cmd_size), 32'(0));
        check_eq("abort_orient", 32'(cmd_orient), 32'(0));
        check_eq("abort_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        pat_size = 4; n_act = 1; act_arr[0] = 2'd2;
        run_pattern(0);

        for (int p = 0; p < 30; p++) begin
            pat_size = 4 << $urandom_range(0, 2);
            n_act    = int'($urandom_range(1, 10));
            for (int i = 0; i < n_act; i++) act_arr[i] = 2'($urandom);
            run_pattern((p % 7 == 3) ? 5 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
